// File: rtl/uart_rx_buf_ctrl_pkg.sv
// Shared types for the UART receive buffer controller.
// Timer states and rx_dout status-bit positions.
package uart_rx_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_COUNT   = 2'd1,
    T_EXPIRED = 2'd2
  } tstate_e;

  function automatic int perr_bit(input int dbo);
    return dbo - 1;
  endfunction

  function automatic int ferr_bit(input int dbo);
    return dbo - 2;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head entry.
// Head is reloaded on first write into empty or on every pop.
module uart_sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, nxt_idx;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             load_head;

  // Bypass the write data when the new head slot is written this cycle.
  always_comb begin
    cnt_d     = cnt_q + LW'(wr_en) - LW'(rd_en);
    nxt_idx   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    load_head = (cnt_d != '0) && ((cnt_q == '0) || rd_en);
    head_d    = (wr_en && (nxt_idx == wr_ptr_q)) ? wr_data
                                                 : mem_q[nxt_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (load_head) head_q <= head_d;
    end
  end

  assign rd_valid = (cnt_q != '0);
  assign rd_data  = head_q;
  assign level    = cnt_q;

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// Receive-side buffer controller: FIFO, sticky flags,
// character-timeout timer and level interrupt.
module uart_rx_buf_ctrl
  import uart_rx_buf_ctrl_pkg::*;
#(
  parameter  int DATA_BIT     = 8,
  parameter  int DATA_BIT_OUT = 10,
  parameter  int DEPTH        = 16,
  parameter  int TIMEOUT_BITS = 40,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             baud_divisor,
  input  logic                    rx_en,
  input  logic                    rx_done_tick,
  input  logic [DATA_BIT_OUT-1:0] rx_dout,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_BIT-1:0]     rd_data,
  output logic                    rd_perr,
  output logic                    rd_ferr,
  output logic [LW-1:0]           level,
  input  logic [LW-1:0]           irq_thresh,
  input  logic                    clr_status,
  output logic                    overrun,
  output logic                    err_seen,
  output logic                    rx_timeout,
  output logic                    irq
);

  localparam int PERR = perr_bit(DATA_BIT_OUT);
  localparam int FERR = ferr_bit(DATA_BIT_OUT);
  localparam int TW   = $clog2(TIMEOUT_BITS + 1);
  localparam int W    = DATA_BIT + 2;

  logic          push, pop, full, wr_en, act, bit_tick;
  logic [LW-1:0] lvl_nxt;
  logic [W-1:0]  wr_data, head;

  assign push    = rx_done_tick & rx_en;
  assign pop     = rd_valid & rd_ready;
  assign full    = (level == LW'(DEPTH));
  assign wr_en   = push & (~full | pop);
  assign wr_data = {rx_dout[PERR], rx_dout[FERR],
                    rx_dout[DATA_BIT-1:0]};
  assign lvl_nxt = level + LW'(wr_en) - LW'(pop);

  uart_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_valid (rd_valid),
    .rd_data  (head),
    .level    (level)
  );

  assign {rd_perr, rd_ferr, rd_data} = head;

  logic overrun_q, overrun_d;
  logic err_seen_q, err_seen_d;
  logic irq_q, irq_d;
  logic tout_q;

  always_comb begin
    overrun_d  = (push & full & ~pop) | (overrun_q & ~clr_status);
    err_seen_d = (wr_en & (wr_data[W-1] | wr_data[W-2]))
               | (err_seen_q & ~clr_status);
    irq_d      = ((irq_thresh != '0) && (level >= irq_thresh))
               | tout_q | overrun_q | err_seen_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q  <= 1'b0;
      err_seen_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      err_seen_q <= err_seen_d;
      irq_q      <= irq_d;
    end
  end

  tstate_e       state_q;
  logic [15:0]   bit_cnt_q;
  logic [TW-1:0] tcnt_q;

  assign act      = push | pop;
  assign bit_tick = (bit_cnt_q >= baud_divisor);

  // Later assignments to tout_q win over the clr_status clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= T_IDLE;
      bit_cnt_q <= '0;
      tcnt_q    <= '0;
      tout_q    <= 1'b0;
    end else begin
      if (clr_status) tout_q <= 1'b0;
      if (rx_en) begin
        unique case (state_q)
          T_IDLE: begin
            bit_cnt_q <= '0;
            tcnt_q    <= '0;
            if (lvl_nxt != '0) state_q <= T_COUNT;
          end
          T_COUNT: begin
            if (lvl_nxt == '0) begin
              state_q   <= T_IDLE;
              bit_cnt_q <= '0;
              tcnt_q    <= '0;
            end else if (act) begin
              bit_cnt_q <= '0;
              tcnt_q    <= '0;
            end else if (bit_tick) begin
              bit_cnt_q <= '0;
              tcnt_q    <= tcnt_q + TW'(1);
              if (tcnt_q == TW'(TIMEOUT_BITS - 1)) begin
                state_q <= T_EXPIRED;
                tout_q  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 16'd1;
            end
          end
          T_EXPIRED: begin
            if (act) begin
              tout_q    <= 1'b0;
              bit_cnt_q <= '0;
              tcnt_q    <= '0;
              state_q   <= (lvl_nxt == '0) ? T_IDLE : T_COUNT;
            end
          end
          default: state_q <= T_IDLE;
        endcase
      end
    end
  end

  assign overrun    = overrun_q;
  assign err_seen   = err_seen_q;
  assign rx_timeout = tout_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Self-checking bench for uart_rx_buf_ctrl with a
// queue-based reference model.
module tb_uart_rx_buf_ctrl;

  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int TB    = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] baud_divisor = 16'd100;
  logic        rx_en = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [9:0]  rx_dout = '0;
  logic        rd_ready = 1'b0;
  logic [LW-1:0] irq_thresh = '0;
  logic        clr_status = 1'b0;
  logic        rd_valid, rd_perr, rd_ferr;
  logic [7:0]  rd_data;
  logic [LW-1:0] level;
  logic        overrun, err_seen, rx_timeout, irq;

  always #5 clk = ~clk;

  uart_rx_buf_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_divisor (baud_divisor),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .rd_ferr      (rd_ferr),
    .level        (level),
    .irq_thresh   (irq_thresh),
    .clr_status   (clr_status),
    .overrun      (overrun),
    .err_seen     (err_seen),
    .rx_timeout   (rx_timeout),
    .irq          (irq)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] q[$];
  bit     m_ovr, m_err, m_tout, m_irq;
  longint ecount = 0;
  longint last_act = 0;

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_err = 0; m_tout = 0; m_irq = 0;
    last_act = ecount;
  endtask

  task automatic model_update();
    bit push, pop, act, full, ovs, ers, ts, nirq;
    logic [9:0] tmp;
    push = rx_done_tick & rx_en;
    pop  = rd_ready && (q.size() != 0);
    nirq = ((irq_thresh != 0) && (q.size() >= int'(irq_thresh)))
           || m_tout || m_ovr || m_err;
    full = (q.size() == DEPTH);
    ovs = 0; ers = 0;
    if (pop) tmp = q.pop_front();
    if (push) begin
      if (full && !pop) ovs = 1;
      else begin
        q.push_back(rx_dout);
        ers = rx_dout[9] | rx_dout[8];
      end
    end
    act = push | pop;
    if (act) last_act = ecount;
    ts = !act && (q.size() != 0) &&
         (ecount - last_act == (longint'(baud_divisor) + 1) * TB);
    m_ovr  = ovs | (m_ovr & !clr_status);
    m_err  = ers | (m_err & !clr_status);
    m_tout = ts | (m_tout & !clr_status & !act);
    m_irq  = nirq;
    ecount++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_done_tick = 1'b0;
    rd_ready = 1'b0;
    clr_status = 1'b0;
    rx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic push_char(input logic [9:0] d);
    rx_done_tick = 1'b1;
    rx_dout = d;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one(output logic [9:0] got);
    got = {rd_perr, rd_ferr, rd_data};
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {rd_valid, rd_data, rd_perr, rd_ferr, level,
            overrun, err_seen, rx_timeout, irq};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h want 0", outs);
    end
    model_reset();
    reset_n = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL post_reset valid %b level %0d want 0 0",
               rd_valid, level);
    end
  endtask

  task automatic test_basic();
    logic [9:0] got;
    do_reset();
    baud_divisor = 16'd100;
    irq_thresh = '0;
    push_char(10'h041);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h41) begin
      errors++;
      $display("FAIL first_word valid %b data %h want 1 41",
               rd_valid, rd_data);
    end
    push_char(10'h042);
    push_char(10'h043);
    checks++;
    if (level !== 5'd3 || rd_data !== 8'h41) begin
      errors++;
      $display("FAIL basic_fill level %0d data %h want 3 41",
               level, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      pop_one(got);
      checks++;
      if (got[7:0] !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL basic_pop%0d got %h want %h",
                 i, got[7:0], 8'h41 + i);
      end
    end
    checks++;
    if (level !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty level %0d valid %b want 0 0",
               level, rd_valid);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    baud_divisor = 16'hffff;
    irq_thresh = '0;
    for (int i = 0; i < 17; i++)
      push_char({2'b00, 8'($urandom)});
    checks++;
    if (overrun !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL overrun_set ovr %b level %0d want 1 16",
               overrun, level);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL overrun_irq got %b want 1", irq);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr got %b want 0", overrun);
    end
  endtask

  task automatic test_full_pushpop();
    logic [9:0] nw, got, exp;
    nw = {2'b00, 8'($urandom)};
    rx_done_tick = 1'b1;
    rx_dout = nw;
    rd_ready = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_pp level %0d ovr %b want 16 0",
               level, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      exp = q[0];
      pop_one(got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drain%0d got %h want %h", i, got, exp);
      end
    end
    checks++;
    if (got !== nw) begin
      errors++;
      $display("FAIL tail_char got %h want %h", got, nw);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] got;
    do_reset();
    baud_divisor = 16'd9;
    irq_thresh = '0;
    push_char({2'b00, 8'($urandom)});
    for (int k = 1; k <= 401; k++) begin
      tick();
      checks++;
      if (rx_timeout !== m_tout) begin
        errors++;
        $display("FAIL tout_cyc%0d got %b want %b",
                 k, rx_timeout, m_tout);
      end
      if (k == 399) begin
        checks++;
        if (rx_timeout !== 1'b0) begin
          errors++;
          $display("FAIL tout_early got %b want 0", rx_timeout);
        end
      end
      if (k == 400) begin
        checks++;
        if (rx_timeout !== 1'b1 || irq !== 1'b0) begin
          errors++;
          $display("FAIL tout_exact tout %b irq %b want 1 0",
                   rx_timeout, irq);
        end
      end
      if (k == 401) begin
        checks++;
        if (irq !== 1'b1) begin
          errors++;
          $display("FAIL tout_irq got %b want 1", irq);
        end
      end
    end
    pop_one(got);
    checks++;
    if (rx_timeout !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL tout_pop tout %b level %0d want 0 0",
               rx_timeout, level);
    end
    repeat (450) tick();
    checks++;
    if (rx_timeout !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL tout_idle tout %b irq %b want 0 0",
               rx_timeout, irq);
    end
  endtask

  task automatic test_errors();
    do_reset();
    baud_divisor = 16'd1000;
    irq_thresh = '0;
    push_char({1'b1, 1'b0, 8'h55});
    checks++;
    if (rd_perr !== 1'b1 || rd_ferr !== 1'b0 ||
        rd_data !== 8'h55 || err_seen !== 1'b1) begin
      errors++;
      $display("FAIL perr_push p %b f %b d %h e %b want 1 0 55 1",
               rd_perr, rd_ferr, rd_data, err_seen);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL perr_irq got %b want 1", irq);
    end
    rx_en = 1'b0;
    rx_done_tick = 1'b1;
    rx_dout = 10'h0aa;
    tick();
    rx_done_tick = 1'b0;
    rx_en = 1'b1;
    checks++;
    if (level !== 5'd1) begin
      errors++;
      $display("FAIL rx_en_off level %0d want 1", level);
    end
    clr_status = 1'b1;
    push_char({1'b0, 1'b1, 8'h3c});
    clr_status = 1'b0;
    checks++;
    if (err_seen !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got %b want 1", err_seen);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (err_seen !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got %b want 0", err_seen);
    end
  endtask

  task automatic test_irq_reset();
    logic [21:0] outs;
    do_reset();
    baud_divisor = 16'd1000;
    irq_thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_char({2'b00, 8'($urandom)});
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL thr_below got %b want 0", irq);
    end
    push_char({2'b00, 8'($urandom)});
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL thr_reg got %b want 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL thr_hit got %b want 1", irq);
    end
    rx_done_tick = 1'b1;
    rx_dout = 10'h0ee;
    #2;
    reset_n = 1'b0;
    #1;
    outs = {rd_valid, rd_data, rd_perr, rd_ferr, level,
            overrun, err_seen, rx_timeout, irq};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", outs);
    end
    rx_done_tick = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL after_reset valid %b level %0d want 0 0",
               rd_valid, level);
    end
  endtask

  task automatic test_random();
    int ph, pp, pr;
    do_reset();
    baud_divisor = 16'($urandom_range(0, 3));
    irq_thresh = LW'($urandom_range(0, 16));
    for (int c = 0; c < 3200; c++) begin
      ph = (c / 200) % 4;
      unique case (ph)
        0: begin pp = 70; pr = 20; end
        1: begin pp = 40; pr = 50; end
        2: begin pp = 0;  pr = 0;  end
        default: begin pp = 15; pr = 85; end
      endcase
      rx_done_tick = ($urandom_range(0, 99) < pp);
      rd_ready = ($urandom_range(0, 99) < pr);
      clr_status = ($urandom_range(0, 49) == 0);
      rx_dout = {$urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 8'($urandom)};
      checks++;
      if (rd_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid c%0d got %b want %b",
                 c, rd_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if ({rd_perr, rd_ferr, rd_data} !== q[0]) begin
          errors++;
          $display("FAIL rnd_head c%0d got %h want %h",
                   c, {rd_perr, rd_ferr, rd_data}, q[0]);
        end
      end
      tick();
      checks++;
      if (level !== LW'(q.size()) || overrun !== m_ovr ||
          err_seen !== m_err || rx_timeout !== m_tout ||
          irq !== m_irq) begin
        errors++;
        $display("FAIL rnd_state c%0d lvl %0d/%0d ovr %b/%b err %b/%b tout %b/%b irq %b/%b",
                 c, level, q.size(), overrun, m_ovr, err_seen,
                 m_err, rx_timeout, m_tout, irq, m_irq);
      end
    end
    rx_done_tick = 1'b0;
    rd_ready = 1'b0;
    clr_status = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_full_pushpop();
    test_timeout();
    test_errors();
    test_irq_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
